// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, the NOP word and the fetch state type.
// Latency: none (declarations only).
// Backpressure: not applicable.
package cpu_pkg;

  // Opcodes seen by the control decoder on instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // AND r0,r0,r0: R-type with no architectural side effects
  localparam logic [31:0] NOP_WORD = 32'h0000_0024;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2
  } fetch_state_t;

  // Instruction addresses are always word aligned
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Program counter register: reset value, aligned target load, +4 increment, hold.
// Latency: new value visible one cycle after load/inc; pc_plus4 is decoded from the register.
// Backpressure: holds whenever neither load nor inc is asserted; load wins over inc.
module pc_reg
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        inc,
  input  logic [31:0] target,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4
);

  // PC update: reset, redirect to aligned target, sequential advance, or hold
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= word_align(RESET_VAL);
    end else if (load) begin
      pc <= word_align(target);
    end else if (inc) begin
      pc <= pc + 32'd4;
    end
  end

  // Wraps naturally at 2^32
  assign pc_plus4 = pc + 32'd4;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: owns the PC, one outstanding imem request, presents one instruction.
// Latency: ack in cycle N -> instr_valid in N+1; consume in M -> next request in M+1.
// Backpressure: stall holds the presented instruction; branch overrides stall and flushes it.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        im_req_o,
  output logic [31:0] im_addr_o,
  input  logic        im_ack_i,
  input  logic [31:0] im_data_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc_plus4_o
);
  import cpu_pkg::*;

  fetch_state_t state;
  fetch_state_t state_nxt;

  // A branch that arrives while a request is in flight is parked here until the ack
  logic        redir_pend;
  logic [31:0] redir_tgt;
  logic [31:0] instr_q;

  logic        ack_fire;
  logic        redirect_now;
  logic        pc_load;
  logic        pc_inc;
  logic [31:0] pc_tgt;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  // Ack only counts while we are actually requesting
  assign ack_fire     = (state == FETCH) && im_ack_i;
  assign redirect_now = redir_pend || branch_taken_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = FETCH;
      FETCH:   if (ack_fire && !redirect_now) state_nxt = ISSUE;
      ISSUE:   if (branch_taken_i || !stall_i) state_nxt = FETCH;
      default: state_nxt = IDLE;
    endcase
  end

  // PC control: redirect on ack-with-redirect or branch in ISSUE, advance on consume
  always_comb begin
    pc_load = 1'b0;
    pc_inc  = 1'b0;
    // A branch seen this cycle is newer than any parked target
    pc_tgt  = branch_taken_i ? branch_target_i : redir_tgt;
    if (state == FETCH) begin
      pc_load = ack_fire && redirect_now;
    end else if (state == ISSUE) begin
      pc_load = branch_taken_i;
      pc_inc  = !branch_taken_i && !stall_i;
    end
  end

  // Redirect bookkeeping for branches that land on an outstanding request
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      redir_pend <= 1'b0;
      redir_tgt  <= 32'h0000_0000;
    end else if (state == FETCH) begin
      if (im_ack_i) begin
        redir_pend <= 1'b0;
      end else if (branch_taken_i) begin
        redir_pend <= 1'b1;
        redir_tgt  <= branch_target_i;
      end
    end
  end

  // Capture returned instruction only when it is still on the architectural path
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      instr_q <= NOP_WORD;
    end else if (ack_fire && !redirect_now) begin
      instr_q <= im_data_i;
    end
  end

  pc_reg #(
    .RESET_VAL(RESET_PC)
  ) u_pc_reg (
    .clk      (clk_i),
    .rst      (rst_i),
    .load     (pc_load),
    .inc      (pc_inc),
    .target   (pc_tgt),
    .pc       (pc),
    .pc_plus4 (pc_plus4)
  );

  // Outputs decoded from registered state only
  always_comb begin
    im_req_o      = (state == FETCH);
    instr_valid_o = (state == ISSUE);
    instr_o       = (state == ISSUE) ? instr_q : NOP_WORD;
    im_addr_o     = pc;
    pc_o          = pc;
    pc_plus4_o    = pc_plus4;
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0024;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        stall_i = 1'b0;
  logic        branch_taken_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic        im_ack_i = 1'b0;
  logic [31:0] im_data_i = 32'h0;
  logic        im_req_o;
  logic [31:0] im_addr_o;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] pc_o;
  logic [31:0] pc_plus4_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk_i           (clk),
    .rst_i           (rst_i),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .im_req_o        (im_req_o),
    .im_addr_o       (im_addr_o),
    .im_ack_i        (im_ack_i),
    .im_data_i       (im_data_i),
    .instr_valid_o   (instr_valid_o),
    .instr_o         (instr_o),
    .pc_o            (pc_o),
    .pc_plus4_o      (pc_plus4_o)
  );

  // Program image: a fixed word at 0, an address-derived pattern elsewhere
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h0) return 32'h2008_0005;
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  // Instruction memory: acks each request after a fixed or random number of wait cycles
  bit mem_rand = 1'b0;
  bit spur_en  = 1'b0;
  int mem_lat  = 0;
  int wcnt     = 0;
  int cur_lat  = 0;

  always begin
    @(posedge clk); #1;
    if (im_req_o !== 1'b1) begin
      wcnt      = 0;
      im_ack_i  = spur_en && ($urandom % 4 == 0);
      im_data_i = $urandom;
    end else begin
      if (im_ack_i) wcnt = 0;
      if (wcnt == 0) cur_lat = mem_rand ? int'($urandom_range(0, 3)) : mem_lat;
      if (wcnt >= cur_lat) begin
        im_ack_i  = 1'b1;
        im_data_i = mem_word(im_addr_o);
      end else begin
        im_ack_i  = 1'b0;
        im_data_i = $urandom;
      end
      wcnt++;
    end
  end

  // Reference model: predicts next-cycle outputs from the fetch rules and tracks program order
  bit          started = 1'b0;
  bit          have_pred = 1'b0;
  bit          p_req, p_valid, p_addr_chk, p_instr_chk;
  logic [31:0] p_addr, p_instr, p_pc;
  bit          idle_next = 1'b0;
  bit          idle_now;
  bit          pend = 1'b0;
  logic [31:0] pend_tgt;
  logic [31:0] exp_pc = 32'h0;
  logic [31:0] t;
  int          n_consume = 0;

  always @(negedge clk) begin
    if (have_pred) begin
      vectors++;
      if (im_req_o !== p_req) begin
        miscompares++;
        $display("FAIL mon_req t=%0t got %b want %b", $time, im_req_o, p_req);
      end
      vectors++;
      if (instr_valid_o !== p_valid) begin
        miscompares++;
        $display("FAIL mon_valid t=%0t got %b want %b", $time, instr_valid_o, p_valid);
      end
      if (p_addr_chk) begin
        vectors++;
        if (im_addr_o !== p_addr) begin
          miscompares++;
          $display("FAIL mon_addr t=%0t got %h want %h", $time, im_addr_o, p_addr);
        end
      end
      if (p_instr_chk) begin
        vectors++;
        if (instr_o !== p_instr || pc_o !== p_pc || pc_plus4_o !== p_pc + 32'd4) begin
          miscompares++;
          $display("FAIL mon_instr t=%0t got %h/%h/%h want %h/%h/%h", $time,
                   instr_o, pc_o, pc_plus4_o, p_instr, p_pc, p_pc + 32'd4);
        end
      end
    end
    if (started && instr_valid_o === 1'b0) begin
      vectors++;
      if (instr_o !== NOP) begin
        miscompares++;
        $display("FAIL mon_nop t=%0t got %h want %h", $time, instr_o, NOP);
      end
    end

    p_addr_chk  = 1'b0;
    p_instr_chk = 1'b0;
    if (rst_i) begin
      started = 1'b1; have_pred = 1'b1;
      p_req = 1'b0; p_valid = 1'b0;
      p_addr_chk = 1'b1; p_addr = 32'h0;
      p_instr_chk = 1'b1; p_instr = NOP; p_pc = 32'h0;
      idle_next = 1'b1; pend = 1'b0; exp_pc = 32'h0;
    end else if (started) begin
      idle_now = idle_next;
      idle_next = 1'b0;
      have_pred = 1'b1;
      if (idle_now) begin
        p_req = 1'b1; p_valid = 1'b0; p_addr_chk = 1'b1; p_addr = 32'h0;
      end else if (instr_valid_o === 1'b1) begin
        if (branch_taken_i) begin
          exp_pc = align(branch_target_i);
          p_req = 1'b1; p_valid = 1'b0; p_addr_chk = 1'b1; p_addr = exp_pc;
        end else if (!stall_i) begin
          n_consume++;
          vectors++;
          if (pc_o !== exp_pc || instr_o !== mem_word(exp_pc)) begin
            miscompares++;
            $display("FAIL mon_order t=%0t got pc %h instr %h want pc %h instr %h", $time,
                     pc_o, instr_o, exp_pc, mem_word(exp_pc));
          end
          exp_pc = exp_pc + 32'd4;
          p_req = 1'b1; p_valid = 1'b0; p_addr_chk = 1'b1; p_addr = exp_pc;
        end else begin
          p_req = 1'b0; p_valid = 1'b1;
          p_instr_chk = 1'b1; p_instr = instr_o; p_pc = pc_o;
        end
      end else if (im_req_o === 1'b1) begin
        if (im_ack_i) begin
          if (branch_taken_i || pend) begin
            t = branch_taken_i ? align(branch_target_i) : pend_tgt;
            exp_pc = t; pend = 1'b0;
            p_req = 1'b1; p_valid = 1'b0; p_addr_chk = 1'b1; p_addr = t;
          end else begin
            p_req = 1'b0; p_valid = 1'b1;
            p_instr_chk = 1'b1; p_instr = mem_word(im_addr_o); p_pc = im_addr_o;
          end
        end else begin
          if (branch_taken_i) begin
            pend = 1'b1; pend_tgt = align(branch_target_i); exp_pc = pend_tgt;
          end
          p_req = 1'b1; p_valid = 1'b0; p_addr_chk = 1'b1; p_addr = im_addr_o;
        end
      end else begin
        have_pred = 1'b0;
        vectors++; miscompares++;
        $display("FAIL mon_live t=%0t neither req nor valid outside idle", $time);
      end
    end
  end

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (instr_valid_o === 1'b1) return;
      cyc();
    end
    vectors++; miscompares++;
    $display("FAIL %s_timeout valid never rose", tag);
  endtask

  task automatic do_reset();
    rst_i = 1'b1; stall_i = 1'b0; branch_taken_i = 1'b0;
    cyc(); cyc();
    rst_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    cyc(); cyc();
    @(negedge clk);
    vectors++;
    if (im_req_o !== 1'b0 || instr_valid_o !== 1'b0 || instr_o !== NOP ||
        pc_o !== 32'h0 || pc_plus4_o !== 32'h4 || im_addr_o !== 32'h0) begin
      miscompares++;
      $display("FAIL reset_state got req %b vld %b instr %h pc %h pc4 %h addr %h want 0 0 %h 0 4 0",
               im_req_o, instr_valid_o, instr_o, pc_o, pc_plus4_o, im_addr_o, NOP);
    end
    cyc();
    rst_i = 1'b0;
  endtask

  task automatic test_first_fetch();
    @(negedge clk);
    vectors++;
    if (im_req_o !== 1'b0) begin miscompares++; $display("FAIL idle_req got %b want 0", im_req_o); end
    cyc(); @(negedge clk);
    vectors++;
    if (im_req_o !== 1'b1 || im_addr_o !== 32'h0) begin
      miscompares++; $display("FAIL first_req got %b @%h want 1 @0", im_req_o, im_addr_o);
    end
    cyc(); @(negedge clk);
    vectors++;
    if (instr_valid_o !== 1'b1 || instr_o !== 32'h2008_0005 || pc_o !== 32'h0 || pc_plus4_o !== 32'h4) begin
      miscompares++;
      $display("FAIL first_issue got %b %h %h %h want 1 20080005 0 4", instr_valid_o, instr_o, pc_o, pc_plus4_o);
    end
    cyc(); @(negedge clk);
    vectors++;
    if (im_req_o !== 1'b1 || im_addr_o !== 32'h4) begin
      miscompares++; $display("FAIL second_req got %b @%h want 1 @4", im_req_o, im_addr_o);
    end
  endtask

  task automatic test_stall();
    wait_valid("stall");
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (instr_valid_o !== 1'b1 || pc_o !== 32'h4 || instr_o !== mem_word(32'h4) || im_req_o !== 1'b0) begin
        miscompares++;
        $display("FAIL stall_hold%0d got %b %h %h req %b want 1 4 %h req 0",
                 i, instr_valid_o, pc_o, instr_o, im_req_o, mem_word(32'h4));
      end
      cyc();
    end
    stall_i = 1'b0;
    cyc(); @(negedge clk);
    vectors++;
    if (im_req_o !== 1'b1 || im_addr_o !== 32'h8) begin
      miscompares++; $display("FAIL stall_release got %b @%h want 1 @8", im_req_o, im_addr_o);
    end
  endtask

  task automatic test_branch_issue();
    wait_valid("br_issue");
    stall_i = 1'b1; branch_taken_i = 1'b1; branch_target_i = 32'h40;
    cyc();
    branch_taken_i = 1'b0; stall_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (instr_valid_o !== 1'b0 || im_req_o !== 1'b1 || im_addr_o !== 32'h40) begin
      miscompares++;
      $display("FAIL br_issue got vld %b req %b @%h want 0 1 @40", instr_valid_o, im_req_o, im_addr_o);
    end
  endtask

  task automatic test_branch_outstanding();
    do_reset();
    mem_lat = 0;
    wait_valid("br_out0");
    cyc();
    wait_valid("br_out4");
    mem_lat = 3;
    cyc();
    branch_taken_i = 1'b1; branch_target_i = 32'h80;
    @(negedge clk);
    vectors++;
    if (im_req_o !== 1'b1 || im_addr_o !== 32'h8) begin
      miscompares++; $display("FAIL br_out_req got %b @%h want 1 @8", im_req_o, im_addr_o);
    end
    cyc();
    branch_taken_i = 1'b0; mem_lat = 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if (im_req_o !== 1'b1 || im_addr_o !== 32'h8 || instr_valid_o !== 1'b0) begin
        miscompares++;
        $display("FAIL br_out_hold%0d got req %b @%h vld %b want 1 @8 0", k, im_req_o, im_addr_o, instr_valid_o);
      end
      cyc();
    end
    @(negedge clk);
    vectors++;
    if (im_req_o !== 1'b1 || im_addr_o !== 32'h80 || instr_valid_o !== 1'b0) begin
      miscompares++;
      $display("FAIL br_out_redir got req %b @%h vld %b want 1 @80 0", im_req_o, im_addr_o, instr_valid_o);
    end
    wait_valid("br_out80");
    vectors++;
    if (pc_o !== 32'h80 || instr_o !== mem_word(32'h80)) begin
      miscompares++; $display("FAIL br_out_target got %h %h want 80 %h", pc_o, instr_o, mem_word(32'h80));
    end
  endtask

  task automatic test_wrap_align();
    wait_valid("align");
    stall_i = 1'b1; branch_taken_i = 1'b1; branch_target_i = 32'h43;
    cyc();
    branch_taken_i = 1'b0; stall_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (im_addr_o !== 32'h40) begin miscompares++; $display("FAIL align_43 got @%h want @40", im_addr_o); end
    wait_valid("wrap_pre");
    stall_i = 1'b1; branch_taken_i = 1'b1; branch_target_i = 32'hFFFF_FFFF;
    cyc();
    branch_taken_i = 1'b0; stall_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (im_addr_o !== 32'hFFFF_FFFC) begin miscompares++; $display("FAIL align_top got @%h want @fffffffc", im_addr_o); end
    wait_valid("wrap");
    @(negedge clk);
    vectors++;
    if (pc_o !== 32'hFFFF_FFFC || pc_plus4_o !== 32'h0) begin
      miscompares++; $display("FAIL wrap_pc4 got %h %h want fffffffc 0", pc_o, pc_plus4_o);
    end
    cyc(); @(negedge clk);
    vectors++;
    if (im_req_o !== 1'b1 || im_addr_o !== 32'h0) begin
      miscompares++; $display("FAIL wrap_req got %b @%h want 1 @0", im_req_o, im_addr_o);
    end
  endtask

  task automatic test_reset_mid();
    mem_lat = 3;
    wait_valid("rst_mid");
    cyc();
    cyc();
    rst_i = 1'b1;
    @(negedge clk);
    vectors++;
    if (im_req_o !== 1'b1) begin miscompares++; $display("FAIL rst_mid_pre got req %b want 1", im_req_o); end
    cyc();
    rst_i = 1'b0;
    @(negedge clk);
    vectors++;
    if (im_req_o !== 1'b0 || instr_valid_o !== 1'b0 || instr_o !== NOP) begin
      miscompares++;
      $display("FAIL rst_mid_state got %b %b %h want 0 0 %h", im_req_o, instr_valid_o, instr_o, NOP);
    end
    cyc(); @(negedge clk);
    vectors++;
    if (im_req_o !== 1'b1 || im_addr_o !== 32'h0) begin
      miscompares++; $display("FAIL rst_mid_req got %b @%h want 1 @0", im_req_o, im_addr_o);
    end
    mem_lat = 0;
  endtask

  task automatic test_random();
    int start_consume;
    start_consume = n_consume;
    mem_rand = 1'b1; spur_en = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      cyc();
      stall_i = ($urandom % 3 == 0);
      if (rst_i) begin
        rst_i = 1'b0; branch_taken_i = 1'b0;
      end else if ($urandom % 400 == 0) begin
        rst_i = 1'b1; branch_taken_i = 1'b0;
      end else begin
        branch_taken_i  = ($urandom % 6 == 0);
        branch_target_i = ($urandom % 2 == 0) ? $urandom : ($urandom % 256);
      end
    end
    cyc();
    rst_i = 1'b0; branch_taken_i = 1'b0; stall_i = 1'b0;
    mem_rand = 1'b0; spur_en = 1'b0;
    cyc(); cyc();
    vectors++;
    if (n_consume - start_consume < 100) begin
      miscompares++;
      $display("FAIL random_progress got %0d consumed want >= 100", n_consume - start_consume);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_fetch();
    test_stall();
    test_branch_issue();
    test_branch_outstanding();
    test_wrap_align();
    test_reset_mid();
    test_random();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
